aes_sub_bytes_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_sbox_lane.sv | 28 ++
 rtl/aes_sub_bytes_seq.sv | 144 ++++++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block size, SubBytes FSM states and the FIPS-197
// forward/inverse S-box lookup tables.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_FWD[b];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SBOX_INV[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: a byte in, its forward or inverse
// substitution out. The inverse table is only built when INV_EN is set.
module aes_sbox_lane
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [7:0] i_byte,
    input  logic       i_inv,
    output logic [7:0] o_byte
);

    logic [7:0] w_fwd;

    assign w_fwd = sbox_fwd(i_byte);

    if (INV_EN) begin : g_inv
        logic [7:0] w_inv;
        assign w_inv  = sbox_inv(i_byte);
        assign o_byte = i_inv ? w_inv : w_fwd;
    end else begin : g_fwd_only
        // Forward-only build: the mode select has nothing to steer.
        logic w_unused_inv;
        assign w_unused_inv = i_inv;
        assign o_byte       = w_fwd;
    end

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes engine. A block is latched on accept, then LANES
// bytes per cycle are substituted in place over ITERS cycles, and the result
// is held in the data register until the downstream handshake completes.
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int STATE_BYTES = AES_BLOCK_BYTES,
    parameter int LANES       = 4,
    parameter bit INV_EN      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*STATE_BYTES-1:0] in_data,
    input  logic                     in_inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*STATE_BYTES-1:0] out_data,
    output logic                     busy
);

    localparam int ITERS    = STATE_BYTES / LANES;
    localparam int CNT_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int LANE_W   = 8 * LANES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    if (LANES < 1 || (STATE_BYTES % LANES) != 0) begin : g_bad_cfg
        $error("aes_sub_bytes_seq: LANES must divide STATE_BYTES");
    end

    sub_state_e                 r_state;
    sub_state_e                 w_state_nxt;
    logic                       w_accept;
    logic [CNT_W-1:0]           r_cnt;
    logic [8*STATE_BYTES-1:0]   r_data;
    logic                       r_inv;
    logic [LANE_W-1:0]          w_lane_in;
    logic [LANE_W-1:0]          w_lane_out;
    logic [8*STATE_BYTES-1:0]   w_data_wb;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs, all derived from the current state.
    // NOTE: every signal gets a default first so no branch can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Select the group of LANES bytes addressed by the counter.
    always_comb begin
        w_lane_in = '0;
        for (int i = 0; i < ITERS; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_lane_in = r_data[i*LANE_W +: LANE_W];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox_lane #(
            .INV_EN (INV_EN)
        ) u_lane (
            .i_byte (w_lane_in[8*g +: 8]),
            .i_inv  (r_inv),
            .o_byte (w_lane_out[8*g +: 8])
        );
    end

    // Write the substituted lanes back over the same byte group.
    always_comb begin
        w_data_wb = r_data;
        for (int i = 0; i < ITERS; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_data_wb[i*LANE_W +: LANE_W] = w_lane_out;
            end
        end
    end

    // Data, mode and counter registers: load on accept, update in place during RUN.
    // NOTE: the data register is an ordinary flop vector, not a memory, so it is reset and out_data reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_inv  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data <= in_data;
                        r_inv  <= INV_EN ? in_inv : 1'b0;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_data <= w_data_wb;
                    if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_data;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Self-checking bench for aes_sub_bytes_seq. The reference S-box is derived
// from GF(2^8) inversion plus the affine map, independent of the RTL tables.
`timescale 1ns/1ps
module tb_aes_sub_bytes_seq;

    localparam int SB   = 16;
    localparam int W    = 8 * SB;
    localparam int N_RT = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int sw_finished = 0;
    bit model_ready = 1'b0;

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] t;
        t = {v, v} << k;
        return t[15:8];
    endfunction

    task automatic build_model();
        logic [7:0] ainv;
        for (int a = 0; a < 256; a++) begin
            ainv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) ainv = 8'(b);
            m_fwd[a] = ainv ^ rotl8(ainv, 1) ^ rotl8(ainv, 2) ^ rotl8(ainv, 3) ^ rotl8(ainv, 4) ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) m_inv[m_fwd[a]] = 8'(a);
    endtask

    function automatic logic [W-1:0] sub_block(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int k = 0; k < SB; k++)
            r[8*k +: 8] = inv ? m_inv[d[8*k +: 8]] : m_fwd[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (defaults, LANES=4) ----------------
    logic         rst_n, rst_n2;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [W-1:0] in_data, out_data;

    aes_sub_bytes_seq #(.STATE_BYTES(SB), .LANES(4), .INV_EN(1'b1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Scoreboard: one expected block in flight, checked every cycle it is visible.
    logic [W-1:0] sb_exp;
    bit           sb_pend = 1'b0;
    bit           sb_seen = 1'b0;
    int           sb_acc  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_pend = 1'b0;
            sb_seen = 1'b0;
        end else if (model_ready) begin
            check(in_ready === !busy, "in_ready_vs_busy", W'(in_ready), W'(!busy));
            if (out_valid) begin
                check(sb_pend, "out_valid_without_block", W'(out_valid), W'(0));
                check(busy === 1'b1, "busy_while_valid", W'(busy), W'(1));
                if (sb_pend) begin
                    if (!sb_seen) begin
                        check(cyc - sb_acc == 4, "latency", W'(cyc - sb_acc), W'(4));
                        sb_seen = 1'b1;
                    end
                    check(out_data === sb_exp, "scoreboard_data", out_data, sb_exp);
                    if (out_ready) sb_pend = 1'b0;
                end
            end else if (sb_pend && sb_seen) begin
                check(out_valid === 1'b1, "out_valid_held", W'(out_valid), W'(1));
            end
            if (in_valid && in_ready) begin
                sb_exp  = sub_block(in_data, in_inv);
                sb_acc  = cyc + 1;
                sb_pend = 1'b1;
                sb_seen = 1'b0;
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic inv);
        bit ok;
        int n;
        in_valid = 1'b1; in_data = d; in_inv = inv; n = 0;
        do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        in_valid = 1'b0; in_data = ~d; in_inv = ~inv;
        check(ok, "accept", W'(ok), W'(1));
    endtask

    task automatic recv(output logic [W-1:0] d, output int lat, output int busy_n);
        bit v;
        int n;
        out_ready = 1'b1; n = 0; busy_n = 0; v = 1'b0; d = '0;
        do begin
            @(negedge clk); v = out_valid; d = out_data;
            if (busy) busy_n++;
            @(posedge clk); #1; n++;
        end while (!v && n < 100);
        lat = n - 1;
        check(v, "out_valid_arrives", W'(v), W'(1));
    endtask

    // ---------------- LANES sweep: 1, 2, 16 ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int L  = (gi == 0) ? 1 : ((gi == 1) ? 2 : 16);
        localparam int IT = SB / L;
        logic         iv, ir, ii, ov, orr, bz;
        logic [W-1:0] id, od;

        aes_sub_bytes_seq #(.STATE_BYTES(SB), .LANES(L), .INV_EN(1'b1)) u_dut (
            .clk (clk), .rst_n (rst_n2), .in_valid (iv), .in_ready (ir), .in_data (id), .in_inv (ii),
            .out_valid (ov), .out_ready (orr), .out_data (od), .busy (bz)
        );

        initial begin
            logic [W-1:0] r, f, got, exp;
            bit ok, v, abort;
            int n;
            iv = 1'b0; ii = 1'b0; id = '0; orr = 1'b1; abort = 1'b0; f = '0; got = '0;
            wait (model_ready && rst_n2);
            @(posedge clk); #1;
            for (int t = 0; t < N_RT && !abort; t++) begin
                r = rand_block();
                for (int p = 0; p < 2 && !abort; p++) begin
                    exp = (p == 0) ? sub_block(r, 1'b0) : r;
                    id  = (p == 0) ? r : f;
                    ii  = (p == 1);
                    iv  = 1'b1; n = 0;
                    do begin
                        @(negedge clk); ok = ir;
                        @(posedge clk); #1; n++;
                    end while (!ok && n < 50);
                    iv = 1'b0; id = ~id; n = 0; v = 1'b0;
                    if (ok) begin
                        do begin
                            @(negedge clk); v = ov; got = od;
                            if (v) check(bz === 1'b1, $sformatf("sw_L%0d_busy", L), W'(bz), W'(1));
                            @(posedge clk); #1; n++;
                        end while (!v && n < 100);
                    end
                    check(ok && v, $sformatf("sw_L%0d_handshake", L), W'({ok, v}), W'(3));
                    if (!(ok && v)) begin
                        abort = 1'b1;
                    end else begin
                        check(n - 1 == IT, $sformatf("sw_L%0d_latency", L), W'(n - 1), W'(IT));
                        check(got === exp, $sformatf("sw_L%0d_%s", L, (p == 0) ? "forward" : "round_trip"), got, exp);
                        f = got;
                    end
                end
            end
            sw_finished++;
        end
    end

    // ---------------- forward-only build ----------------
    logic         f_iv, f_ir, f_ii, f_ov, f_or, f_bz;
    logic [W-1:0] f_id, f_od;

    aes_sub_bytes_seq #(.STATE_BYTES(SB), .LANES(4), .INV_EN(1'b0)) u_fwd_only (
        .clk (clk), .rst_n (rst_n2), .in_valid (f_iv), .in_ready (f_ir), .in_data (f_id), .in_inv (f_ii),
        .out_valid (f_ov), .out_ready (f_or), .out_data (f_od), .busy (f_bz)
    );

    initial begin
        logic [W-1:0] blk, got, exp;
        bit ok, v;
        int n;
        f_iv = 1'b0; f_ii = 1'b0; f_id = '0; f_or = 1'b1; got = '0;
        wait (model_ready && rst_n2);
        @(posedge clk); #1;
        for (int t = 0; t < 8; t++) begin
            if (t == 0) begin
                blk = '0;
                exp = {16{8'h63}};
            end else begin
                blk = rand_block();
                exp = sub_block(blk, 1'b0);
            end
            f_id = blk; f_ii = 1'b1; f_iv = 1'b1; n = 0;
            do begin
                @(negedge clk); ok = f_ir;
                @(posedge clk); #1; n++;
            end while (!ok && n < 50);
            f_iv = 1'b0; n = 0; v = 1'b0;
            do begin
                @(negedge clk); v = f_ov; got = f_od;
                @(posedge clk); #1; n++;
            end while (!v && n < 100);
            check(ok && v && f_bz === 1'b0, "fwd_only_handshake", W'({ok, v}), W'(3));
            check(got === exp, "fwd_only_ignores_inv", got, exp);
        end
        sw_finished++;
    end

    // ---------------- directed sequence on the main DUT ----------------
    initial begin
        logic [W-1:0] got, blk, blk_a, blk_b, held, fwd;
        int lat, bn, n;

        rst_n = 1'b0; rst_n2 = 1'b0;
        in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
        build_model();

        // Pin the reference model with FIPS-197 values.
        check(m_fwd[8'h00] === 8'h63, "model_fwd_00", W'(m_fwd[8'h00]), W'(8'h63));
        check(m_fwd[8'h53] === 8'hed, "model_fwd_53", W'(m_fwd[8'h53]), W'(8'hed));
        check(m_fwd[8'hff] === 8'h16, "model_fwd_ff", W'(m_fwd[8'hff]), W'(8'h16));
        check(m_inv[8'h00] === 8'h52, "model_inv_00", W'(m_inv[8'h00]), W'(8'h52));
        check(m_inv[8'h53] === 8'h50, "model_inv_53", W'(m_inv[8'h53]), W'(8'h50));
        check(m_inv[8'hff] === 8'h7d, "model_inv_ff", W'(m_inv[8'hff]), W'(8'h7d));
        model_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check(in_ready === 1'b1, "reset_in_ready", W'(in_ready), W'(1));
        check(out_valid === 1'b0, "reset_out_valid", W'(out_valid), W'(0));
        check(busy === 1'b0, "reset_busy", W'(busy), W'(0));
        check(out_data === '0, "reset_out_data", out_data, '0);
        rst_n = 1'b1; rst_n2 = 1'b1;
        @(posedge clk); #1;

        // All-zero block, forward, downstream always ready.
        out_ready = 1'b1;
        send('0, 1'b0);
        recv(got, lat, bn);
        check(got === {16{8'h63}}, "zero_block_fwd", got, {16{8'h63}});
        check(lat == 4, "zero_block_latency", W'(lat), W'(4));
        check(bn == 5, "zero_block_busy_cycles", W'(bn), W'(5));
        @(negedge clk);
        check(busy === 1'b0, "busy_low_after_done", W'(busy), W'(0));
        @(posedge clk); #1;

        // Edge bytes 0x53 / 0xFF, forward then inverse.
        blk = {8'hff, 112'h0, 8'h53};
        send(blk, 1'b0);
        recv(got, lat, bn);
        check(got === {8'h16, {14{8'h63}}, 8'hed}, "edge_bytes_fwd", got, {8'h16, {14{8'h63}}, 8'hed});
        send(blk, 1'b1);
        recv(got, lat, bn);
        check(got === {8'h7d, {14{8'h52}}, 8'h50}, "edge_bytes_inv", got, {8'h7d, {14{8'h52}}, 8'h50});

        // Random round trips; send() scrambles in_data/in_inv during RUN.
        for (int t = 0; t < N_RT; t++) begin
            blk = rand_block();
            send(blk, 1'b0);
            recv(fwd, lat, bn);
            check(fwd === sub_block(blk, 1'b0), "rt_forward", fwd, sub_block(blk, 1'b0));
            send(fwd, 1'b1);
            recv(got, lat, bn);
            check(got === blk, "rt_round_trip", got, blk);
        end

        // Backpressure with a second block waiting.
        out_ready = 1'b0;
        blk_a = rand_block();
        blk_b = rand_block();
        send(blk_a, 1'b0);
        in_valid = 1'b1; in_data = blk_b; in_inv = 1'b1; n = 0;
        do begin
            @(negedge clk); n++;
        end while (!out_valid && n < 20);
        check(out_valid === 1'b1, "bp_first_valid", W'(out_valid), W'(1));
        held = out_data;
        check(held === sub_block(blk_a, 1'b0), "bp_first_data", held, sub_block(blk_a, 1'b0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check(out_valid === 1'b1 && out_data === held, "bp_hold_output", out_data, held);
            check(in_ready === 1'b0, "bp_hold_in_ready", W'(in_ready), W'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check(out_valid === 1'b0, "bp_valid_drops", W'(out_valid), W'(1'b0));
        check(in_ready === 1'b1, "bp_second_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0; in_inv = 1'b0;
        recv(got, lat, bn);
        check(got === sub_block(blk_b, 1'b1), "bp_second_block", got, sub_block(blk_b, 1'b1));
        check(lat == 4, "bp_second_latency", W'(lat), W'(4));

        // Reset in the middle of RUN (cnt = 2).
        blk = rand_block();
        send(blk, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check(out_valid === 1'b0, "midrun_rst_out_valid", W'(out_valid), W'(0));
        check(in_ready === 1'b1, "midrun_rst_in_ready", W'(in_ready), W'(1));
        check(busy === 1'b0, "midrun_rst_busy", W'(busy), W'(0));
        check(out_data === '0, "midrun_rst_out_data", out_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check(out_valid === 1'b0, "post_rst_no_valid", W'(out_valid), W'(0));
        end
        @(posedge clk); #1;
        blk = rand_block();
        send(blk, 1'b1);
        recv(got, lat, bn);
        check(got === sub_block(blk, 1'b1), "post_rst_block", got, sub_block(blk, 1'b1));

        // Wait for the parallel instances, bounded.
        n = 0;
        while (sw_finished < 4 && n < 80000) begin
            @(posedge clk); n++;
        end
        check(sw_finished == 4, "parallel_instances_finish", W'(sw_finished), W'(4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
